// File: rtl/mesh_mm_pkg.sv
// mesh_mm_pkg: shared types and constants for the 2D-mesh matrix multiplier.
//   state_t      controller state encoding (S_IDLE..S_FIN)
//   feed_steps() number of skewed injection cycles for an n x n product
//   RES_W        width of each result register
package mesh_mm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_LOAD  = 3'd3;
    localparam state_t S_FIN   = 3'd4;

    localparam int RES_W = 12;

    function automatic int feed_steps(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/mesh_skew_dec.sv
// mesh_skew_dec: combinational injection-window decode for the skewed operand feeders.
//   STEP  in  SW  injection step index t
//   A_VLD out N   bit i high when row i of A injects this step (i <= t < i+N)
//   B_VLD out N   bit j high when column j of B injects this step (same window)
module mesh_skew_dec #(
    parameter int N  = 3,
    parameter int SW = $clog2(3 * N - 2)
) (
    input  logic [SW-1:0] STEP,
    output logic [N-1:0]  A_VLD,
    output logic [N-1:0]  B_VLD
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_win
            assign A_VLD[i] = (int'(STEP) >= i) && (int'(STEP) < i + N);
        end
    endgenerate

    assign B_VLD = A_VLD;

endmodule

// File: rtl/mesh_mm_ctrl.sv
// mesh_mm_ctrl: sequences one N x N product through the PE mesh per START pulse.
//   CLK, RST      clock (rising edge), asynchronous active-low reset
//   START, HOLD   begin a product (IDLE only), stall request (FEED only)
//   BUSY, DONE    in-progress flag, one-cycle completion pulse
//   ACC_CLR       clear PE accumulators, PE_EN mesh accumulate/shift enable
//   STEP          injection step index, A_VLD/B_VLD per-row/column inject strobes
//   RES_EN        load enable for the result register bank
module mesh_mm_ctrl
    import mesh_mm_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          HOLD,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ACC_CLR,
    output logic                          PE_EN,
    output logic [$clog2(3 * N - 2)-1:0]  STEP,
    output logic [N-1:0]                  A_VLD,
    output logic [N-1:0]                  B_VLD,
    output logic                          RES_EN
);

    localparam int SW = $clog2(3 * N - 2);
    localparam logic [SW-1:0] LAST = SW'(feed_steps(N) - 1);

    state_t        state, nxt;
    logic [SW-1:0] step, nxt_step;
    logic          feed, adv, last;
    logic [N-1:0]  win_a, win_b;

    assign feed = state == S_FEED;
    assign adv  = feed && !HOLD;
    assign last = step == LAST;

    // step returns to 0 on leaving FEED so it reads 0 in every other state
    always_comb begin
        nxt      = state == S_IDLE  ? (START ? S_CLEAR : S_IDLE) :
                   state == S_CLEAR ? S_FEED :
                   state == S_FEED  ? (adv && last ? S_LOAD : S_FEED) :
                   state == S_LOAD  ? S_FIN : S_IDLE;
        nxt_step = adv ? (last ? '0 : step + 1'b1) : (feed ? step : '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            step  <= '0;
        end else begin
            state <= nxt;
            step  <= nxt_step;
        end
    end

    mesh_skew_dec #(.N(N), .SW(SW)) u_skew (
        .STEP  (step),
        .A_VLD (win_a),
        .B_VLD (win_b)
    );

    // HOLD is the only input allowed to reach outputs directly, and only to gate injection
    assign BUSY    = state != S_IDLE;
    assign ACC_CLR = state == S_CLEAR;
    assign RES_EN  = state == S_LOAD;
    assign DONE    = state == S_FIN;
    assign PE_EN   = adv;
    assign STEP    = step;
    assign A_VLD   = {N{adv}} & win_a;
    assign B_VLD   = {N{adv}} & win_b;

endmodule

// File: tb/tb_mesh_mm_ctrl.sv
// tb_mesh_mm_ctrl: self-checking bench for mesh_mm_ctrl (N=3 and N=4 instances).
module tb_mesh_mm_ctrl;
    import mesh_mm_pkg::*;

    typedef struct {
        logic        start;
        logic        hold;
        logic [13:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic RST, START, HOLD, start4;
    logic BUSY, DONE, ACC_CLR, PE_EN, RES_EN;
    logic [2:0] STEP, A_VLD, B_VLD;
    logic busy4, done4, acc_clr4, pe_en4, res_en4;
    logic [3:0] step4, a_vld4, b_vld4;
    logic [13:0] got3;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv[$];

    int ma[3][3];
    int mb[3][3];
    int k;
    logic [RES_W-1:0] acc[3][3];
    logic [RES_W-1:0] res[3][3];

    always #5 CLK = ~CLK;

    mesh_mm_ctrl #(.N(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD),
        .BUSY(BUSY), .DONE(DONE), .ACC_CLR(ACC_CLR), .PE_EN(PE_EN),
        .STEP(STEP), .A_VLD(A_VLD), .B_VLD(B_VLD), .RES_EN(RES_EN)
    );

    mesh_mm_ctrl #(.N(4)) dut4 (
        .CLK(CLK), .RST(RST), .START(start4), .HOLD(1'b0),
        .BUSY(busy4), .DONE(done4), .ACC_CLR(acc_clr4), .PE_EN(pe_en4),
        .STEP(step4), .A_VLD(a_vld4), .B_VLD(b_vld4), .RES_EN(res_en4)
    );

    assign got3 = {BUSY, DONE, ACC_CLR, PE_EN, RES_EN, STEP, A_VLD, B_VLD};

    // behavioural 3x3 output-stationary mesh: PE(i,j) sees k = t-i-j at step t
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    acc[i][j] <= '0;
                    res[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    k = int'(STEP) - i - j;
                    if (ACC_CLR)
                        acc[i][j] <= '0;
                    else if (PE_EN && k >= 0 && k < 3)
                        acc[i][j] <= acc[i][j] + RES_W'(ma[i][k] * mb[k][j]);
                    if (RES_EN)
                        res[i][j] <= acc[i][j];
                end
        end
    end

    function automatic logic [13:0] o(input logic b, d, c, p, r, input int s, input logic [2:0] a);
        return {b, d, c, p, r, 3'(s), a, a};
    endfunction

    task automatic add(input logic st, input logic hd, input logic [13:0] e);
        vec_t v;
        v.start = st;
        v.hold  = hd;
        v.exp   = e;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_product();
        int sum;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                sum = 0;
                for (int q = 0; q < 3; q++) sum += ma[i][q] * mb[q][j];
                chk($sformatf("res[%0d][%0d]", i, j), 32'(res[i][j]), 32'(RES_W'(sum)));
            end
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while (!DONE && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(DONE), 32'd1);
    endtask

    logic [2:0] aw[7];
    logic [13:0] idle_o, clr_o, load_o, fin_o;

    initial begin
        int n, dcyc;
        RST = 1'b0; START = 1'b0; HOLD = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 3 * i + j + 1;
            end
        aw = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
        idle_o = o(0, 0, 0, 0, 0, 0, 3'b000);
        clr_o  = o(1, 0, 1, 0, 0, 0, 3'b000);
        load_o = o(1, 0, 0, 0, 1, 0, 3'b000);
        fin_o  = o(1, 1, 0, 0, 0, 0, 3'b000);
        // nominal run: rows 0..11
        add(1, 0, idle_o);
        add(0, 0, clr_o);
        for (int s = 0; s < 7; s++) add(0, 0, o(1, 0, 0, 1, 0, s, aw[s]));
        add(0, 0, load_o);
        add(0, 0, fin_o);
        add(0, 0, idle_o);
        // HOLD for two cycles at STEP=3, plus HOLD in LOAD/FIN/IDLE: rows 12..25
        add(1, 0, idle_o);
        add(0, 0, clr_o);
        for (int s = 0; s < 3; s++) add(0, 0, o(1, 0, 0, 1, 0, s, aw[s]));
        add(0, 1, o(1, 0, 0, 0, 0, 3, 3'b000));
        add(0, 1, o(1, 0, 0, 0, 0, 3, 3'b000));
        for (int s = 3; s < 7; s++) add(0, 0, o(1, 0, 0, 1, 0, s, aw[s]));
        add(0, 1, load_o);
        add(0, 1, fin_o);
        add(0, 1, idle_o);
        // START while busy ignored; START right after FIN accepted: rows 26..38
        add(1, 0, idle_o);
        add(1, 0, clr_o);
        for (int s = 0; s < 7; s++) add(s == 2, 0, o(1, 0, 0, 1, 0, s, aw[s]));
        add(1, 0, load_o);
        add(1, 0, fin_o);
        add(1, 0, idle_o);
        add(0, 0, clr_o);

        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("idle3", 32'(got3), 32'd0);
            chk("idle4", 32'({busy4, done4, acc_clr4, pe_en4, res_en4, step4, a_vld4}), 32'd0);
        end
        @(posedge CLK); #1;

        for (int c = 0; c < tv.size(); c++) begin
            START = tv[c].start;
            HOLD  = tv[c].hold;
            @(negedge CLK);
            chk($sformatf("vec%0d", c), 32'(got3), 32'(tv[c].exp));
            if (c == 11)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        chk($sformatf("ident_res[%0d][%0d]", i, j), 32'(res[i][j]), 32'(3 * i + j + 1));
            @(posedge CLK); #1;
        end
        START = 1'b0;
        HOLD  = 1'b0;

        // restarted product is in FEED STEP 0 now; new operands apply to every accumulation
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = (i + j) % 3 + 1;
                mb[i][j] = 9 - 3 * i - j;
            end
        wait_done("restart_done");
        chk_product();

        // reset mid-FEED at STEP=4
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        n = 0;
        @(negedge CLK);
        while (STEP != 3'd4 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_step4", 32'(STEP), 32'd4);
        #1 RST = 1'b0;
        #1 chk("rst_outputs", 32'(got3), 32'd0);
        @(posedge CLK); #1 RST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("post_rst_idle", 32'(got3), 32'd0);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) ma[i][j] = (i == j) ? 2 : 0;
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        wait_done("after_rst_done");
        chk_product();

        // N=4 instance
        @(posedge CLK); #1 start4 = 1'b1;
        dcyc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (done4) dcyc = c;
            if (c >= 2 && c <= 11) begin
                chk($sformatf("n4_step%0d", c), 32'(step4), 32'(c - 2));
                chk($sformatf("n4_a3_%0d", c), 32'(a_vld4[3]), 32'(c - 2 >= 3 && c - 2 <= 6));
            end
            @(posedge CLK); #1 start4 = 1'b0;
        end
        chk("n4_done_cycle", 32'(dcyc), 32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mesh_mm_ctrl.md
# mesh_mm_ctrl

Sequencing controller for the 2D-mesh matrix multiplier. One START pulse runs one full N×N product through the PE mesh:
- clears the PE accumulators;
- steps the skewed operand injection for 3N-2 cycles;
- pulses the load enable of the 12-bit result registers (the EN of each result register);
- signals DONE.

It sits between the host/top-level and the mesh, operand feeders and result register bank.

## Interface
- N, default 3: mesh dimension (rows = columns = inner dimension), N ≥ 2.
- SW, derived localparam = $clog2(3N-2): STEP width; not overridable.

Ports:
- CLK  in  1  master clock, rising edge.
- RST  in  1  master reset, asynchronous, active-low.
- START  in  1  begin a product; sampled only in IDLE.
- HOLD  in  1  stall request; effective only in FEED.
- BUSY  out  1  high from the cycle after START acceptance through the DONE cycle.
- DONE  out  1  one-cycle pulse: result registers hold the new product.
- ACC_CLR  out  1  synchronous clear to all PE accumulators.
- PE_EN  out  1  mesh accumulate/shift enable.
- STEP  out  SW  injection step index t, 0..3N-3.
- A_VLD  out  N  bit i: row i of A injects element A[i][t-i] this cycle.
- B_VLD  out  N  bit j: column j of B injects element B[t-j][j] this cycle.
- RES_EN  out  1  load enable to every result register.

## Operation
- FSM states: IDLE, CLEAR, FEED, LOAD, FIN.
- IDLE:
  - all outputs 0;
  - START=1 → CLEAR.
- CLEAR: one cycle; ACC_CLR=1, BUSY=1, STEP=0 → FEED.
- FEED:
  - BUSY=1; STEP counts 0..3N-3.
  - When HOLD=0: PE_EN=1; A_VLD[i]=(i ≤ STEP < i+N); B_VLD[j] uses the same rule. STEP increments at the clock edge. If STEP=3N-3 → LOAD.
  - When HOLD=1: PE_EN=0, A_VLD=B_VLD=0, STEP frozen, state held.
- LOAD: one cycle; RES_EN=1, BUSY=1 → FIN. HOLD is ignored.
- FIN: one cycle; DONE=1, BUSY=1 → IDLE. START is ignored.
- Outputs are decoded from registered state/STEP only. START and HOLD never reach outputs combinationally, except HOLD gating PE_EN/A_VLD/B_VLD in FEED.
- START while BUSY is ignored and not queued.
- HOLD outside FEED has no effect.
- STEP is 0 in every state except FEED.

## Timing
- Reset value of every output is 0; state = IDLE; STEP = 0.
- START=1 in IDLE at cycle 0:
  - cycle 1: CLEAR;
  - cycles 2..3N-1: FEED, 3N-2 active cycles;
  - cycle 3N: LOAD;
  - cycle 3N+1: FIN/DONE.
- Each held FEED cycle adds one cycle to the latency.
- N=3 with no HOLD: DONE in cycle 10.
- The last PE update occurs at the edge closing the final FEED cycle, so the result registers capture valid D at the edge closing LOAD. Their Q is valid during FIN and after.
- Earliest restart: START in the cycle after FIN (state IDLE) is accepted.
- RST low at any time, including mid-FEED: immediate return to IDLE with all outputs 0. The partial product is discarded; the result registers are reset by the same RST.

## Structure
- Shared package mesh_mm_pkg holds:
  - the state typedef (IDLE, CLEAR, FEED, LOAD, FIN);
  - function feed_steps(N) = 3N-2;
  - a result-width constant of 12.
- Sub-module mesh_skew_dec (N, SW): purely combinational STEP → A_VLD/B_VLD window decode, reused by the operand feeders.
- FSM and STEP counter stay in mesh_mm_ctrl.

## Test plan
- Reset: assert RST low mid-simulation → all outputs 0 within the same cycle. Release RST, hold START=0 for 20 cycles → outputs stay 0.
- Nominal N=3: START pulse at cycle 0 → checks:
  - ACC_CLR at cycle 1;
  - STEP 0..6 over cycles 2..8;
  - A_VLD = 001, 011, 111, 110, 100, 000… following the window rule;
  - RES_EN at cycle 9; DONE at cycle 10.
  - With identity A and B=[1..9], result registers read 1..9 after DONE.
- HOLD: HOLD=1 for 2 cycles while STEP=3 → STEP stays 3, PE_EN=0 and A_VLD=0 in those cycles; DONE moves to cycle 12.
- START while busy: pulse START in CLEAR, FEED and FIN → ignored; exactly one DONE. A START in the cycle after FIN is accepted (CLEAR in the next cycle).
- Reset mid-FEED: RST low at STEP=4 → IDLE, STEP=0, no RES_EN/DONE. A new START yields a correct full product.
- N=4 build: STEP 0..9, DONE at cycle 13; A_VLD[3] high exactly for STEP 3..6.
